fsm_rr_detect_sched: RTL and testbench

Time-multiplexed scheduler that shares one copy of the team's 2-bit Mealy detector next-state/output logic among NCH serial bit-stream requesters. Each channel has its own stored {y1,y2} state. A round-robin arbiter grants one channel per cycle through a valid/ready handshake. The registered result is returned with the channel id. The block sits between the per-channel serial front ends and the detection-event consumer.

---
 rtl/fsm_rr_detect_sched.sv | 144 ++++++++++++++
 tb/tb_fsm_rr_detect_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_detect_sched.sv
// Round-robin scheduler sharing one 2-bit Mealy detector among NCH serial channels.
// Optional per-channel saturating detection counters: define DETECT_COUNT_EN.
module fsm_rr_detect_sched #(
   parameter int NCH  = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   req_valid,
   input  logic [NCH-1:0]   req_bit,
   output logic [NCH-1:0]   req_ready,
   input  logic [NCH-1:0]   ch_clear,
   output logic             det_valid,
   output logic [IDW-1:0]   det_ch,
   output logic             det_out,
   output logic [1:0]       det_state
`ifdef DETECT_COUNT_EN
   ,
   input  logic [IDW-1:0]   cnt_sel,
   output logic [CNTW-1:0]  cnt_rd
`endif
);

   if (NCH < 2 || IDW < $clog2(NCH) || CNTW < 1) begin : g_bad_cfg
      $error("fsm_rr_detect_sched: illegal parameters");
   end

   logic [1:0]     st_q [NCH];
   logic [1:0]     st_d [NCH];
   logic [IDW-1:0] ptr_q, ptr_d;
   logic           dv_q, dv_d;
   logic [IDW-1:0] ch_q, ch_d;
   logic           out_q, out_d;
   logic [1:0]     ds_q, ds_d;

   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   logic           y1, y2, bin;
   logic           ny1, ny2, mout;
   int             idx;

   // Scan ptr, ptr+1, ... wrapping; first eligible channel wins.
   always_comb begin
      req_ready = '0;
      gnt_vld   = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NCH) idx = idx - NCH;
         for (int i = 0; i < NCH; i++) begin
            if (!gnt_vld && i == idx && req_valid[i] && !ch_clear[i]) begin
               gnt_vld      = 1'b1;
               gnt_id       = IDW'(i);
               req_ready[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      y1  = 1'b0;
      y2  = 1'b0;
      bin = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (req_ready[i]) begin
            {y1, y2} = st_q[i];
            bin      = req_bit[i];
         end
      end
      ny1  = ~y1 | (bin ^ y2);
      ny2  = bin;
      mout = (~y1 & y2 & ~bin) | (y1 & ~y2 & bin);
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         st_d[i] = st_q[i];
         if (ch_clear[i])       st_d[i] = 2'b00;
         else if (req_ready[i]) st_d[i] = {ny1, ny2};
      end
      ptr_d = ptr_q;
      dv_d  = gnt_vld;
      ch_d  = ch_q;
      out_d = 1'b0;
      ds_d  = ds_q;
      if (gnt_vld) begin
         ptr_d = (gnt_id == IDW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
         ch_d  = gnt_id;
         out_d = mout;
         ds_d  = {ny1, ny2};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) st_q[i] <= 2'b00;
         ptr_q <= '0;
         dv_q  <= 1'b0;
         ch_q  <= '0;
         out_q <= 1'b0;
         ds_q  <= 2'b00;
      end else begin
         for (int i = 0; i < NCH; i++) st_q[i] <= st_d[i];
         ptr_q <= ptr_d;
         dv_q  <= dv_d;
         ch_q  <= ch_d;
         out_q <= out_d;
         ds_q  <= ds_d;
      end
   end

   assign det_valid = dv_q;
   assign det_ch    = ch_q;
   assign det_out   = out_q;
   assign det_state = ds_q;

`ifdef DETECT_COUNT_EN
   logic [CNTW-1:0] cnt_q [NCH];

   // Saturate rather than wrap so a busy channel never reads back as quiet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ch_clear[i])
               cnt_q[i] <= '0;
            else if (req_ready[i] && mout && cnt_q[i] != '1)
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_rd = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cnt_sel == IDW'(i)) cnt_rd = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fsm_rr_detect_sched.sv
// Bench for fsm_rr_detect_sched: directed plan steps plus random traffic
// against a behavioural model of the scheduler and detector.
module tb_fsm_rr_detect_sched;
   localparam int NCH = 4;
   localparam int IDW = 2;
`ifdef DETECT_COUNT_EN
   localparam int CNTW = 2;
`else
   localparam int CNTW = 8;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] req_valid, req_bit, req_ready, ch_clear;
   logic           det_valid, det_out;
   logic [IDW-1:0] det_ch;
   logic [1:0]     det_state;
`ifdef DETECT_COUNT_EN
   logic [IDW-1:0]  cnt_sel;
   logic [CNTW-1:0] cnt_rd;
`endif

   fsm_rr_detect_sched #(.NCH(NCH), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_bit(req_bit), .req_ready(req_ready),
      .ch_clear(ch_clear),
      .det_valid(det_valid), .det_ch(det_ch),
      .det_out(det_out), .det_state(det_state)
`ifdef DETECT_COUNT_EN
      , .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int mst [NCH];
   int mcnt [NCH];
   int mptr, mdv, mch, mout, mstate;
   logic [NCH-1:0] rdy_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         mst[i]  = 0;
         mcnt[i] = 0;
      end
      mptr = 0; mdv = 0; mch = 0; mout = 0; mstate = 0;
   endtask

   function automatic int model_grant(logic [NCH-1:0] v, logic [NCH-1:0] c);
      for (int k = 0; k < NCH; k++) begin
         int i = (mptr + k) % NCH;
         if (v[i] && !c[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_dv"}, 32'(det_valid), 0);
      chk({tag, "_ch"}, 32'(det_ch), 0);
      chk({tag, "_out"}, 32'(det_out), 0);
      chk({tag, "_st"}, 32'(det_state), 0);
`ifdef DETECT_COUNT_EN
      for (int i = 0; i < NCH; i++) begin
         cnt_sel = IDW'(i);
         #1 chk({tag, "_cnt"}, 32'(cnt_rd), 0);
      end
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0; req_bit = '0; ch_clear = '0;
      #2 reset = 1'b1;
      #1 check_zero("rst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                       input logic [NCH-1:0] c, input string tag);
      int g, y1, y2, in, ny1, o;
      logic [NCH-1:0] er;
      @(negedge clk);
      req_valid = v; req_bit = b; ch_clear = c;
`ifdef DETECT_COUNT_EN
      cnt_sel = IDW'($urandom_range(0, NCH - 1));
`endif
      #1;
      g  = model_grant(v, c);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      rdy_seen = req_ready;
      chk({tag, "_ready"}, 32'(req_ready), 32'(er));
`ifdef DETECT_COUNT_EN
      chk({tag, "_cnt"}, 32'(cnt_rd), 32'(mcnt[cnt_sel]));
`endif
      @(posedge clk);
      if (g >= 0) begin
         y1  = mst[g] / 2;
         y2  = mst[g] % 2;
         in  = int'(b[g]);
         ny1 = (y1 == 0 || in != y2) ? 1 : 0;
         o   = ((y1 == 0 && y2 == 1 && in == 0) ||
                (y1 == 1 && y2 == 0 && in == 1)) ? 1 : 0;
         mst[g] = ny1 * 2 + in;
         mdv = 1; mch = g; mout = o; mstate = mst[g];
         mptr = (g + 1) % NCH;
         if (o == 1 && mcnt[g] < (1 << CNTW) - 1) mcnt[g]++;
      end else begin
         mdv = 0; mout = 0;
      end
      for (int i = 0; i < NCH; i++) begin
         if (c[i]) begin
            mst[i]  = 0;
            mcnt[i] = 0;
         end
      end
      #1;
      chk({tag, "_dv"}, 32'(det_valid), 32'(mdv));
      chk({tag, "_ch"}, 32'(det_ch), 32'(mch));
      chk({tag, "_out"}, 32'(det_out), 32'(mout));
      chk({tag, "_st"}, 32'(det_state), 32'(mstate));
   endtask

   initial begin
      int exp_out [4] = '{0, 1, 0, 1};
      int exp_st  [4] = '{2, 3, 1, 2};
      logic [3:0] pat;
      reset = 1'b1;
      req_valid = '0; req_bit = '0; ch_clear = '0;
`ifdef DETECT_COUNT_EN
      cnt_sel = '0;
`endif
      model_reset();
      #12 check_zero("por");
      req_valid = 4'hF;
      #1 chk("por_ready", 32'(req_ready), 32'h1);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;

      pat = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         step(4'b0001, {3'b000, pat[3-k]}, '0, "t1");
         chk("t1_out_fix", 32'(det_out), 32'(exp_out[k]));
         chk("t1_st_fix", 32'(det_state), 32'(exp_st[k]));
      end
      step('0, '0, '0, "t1_idle");
      chk("t1_idle_dv", 32'(det_valid), 0);

      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(4'hF, 4'($urandom), '0, "t2");
         chk("t2_gnt_fix", 32'(rdy_seen), 32'(1 << (k % 4)));
         chk("t2_ch_fix", 32'(det_ch), 32'(k % 4));
      end

      for (int k = 0; k < 5; k++) begin
         step(4'b0100, 4'($urandom), '0, "t3");
         chk("t3_ch_fix", 32'(det_ch), 2);
         chk("t3_dv_fix", 32'(det_valid), 1);
      end

      do_reset();
      step(4'b0001, 4'b0000, '0, "t4a");
      chk("t4_o0", 32'(det_out), 0);
      step(4'b0010, 4'b0010, '0, "t4b");
      chk("t4_o1", 32'(det_out), 0);
      step(4'b0001, 4'b0001, '0, "t4c");
      chk("t4_o2", 32'(det_out), 1);
      chk("t4_s0", 32'(det_state), 3);
      step(4'b0010, 4'b0010, '0, "t4d");
      chk("t4_o3", 32'(det_out), 0);
      chk("t4_s1", 32'(det_state), 1);

      do_reset();
      step(4'b0010, 4'b0000, '0, "t5a");
      chk("t5_s10", 32'(det_state), 2);
      step(4'b0110, 4'b0000, 4'b0010, "t5b");
      chk("t5_mask", 32'(rdy_seen), 32'h4);
      step(4'b0010, 4'b0000, '0, "t5c");
      chk("t5_cleared", 32'(det_state), 2);

`ifdef DETECT_COUNT_EN
      do_reset();
      for (int k = 0; k < 10; k++) step(4'b0001, 4'(k % 2), '0, "t6");
      @(negedge clk);
      req_valid = '0;
      cnt_sel = '0;
      #1 chk("t6_sat", 32'(cnt_rd), 3);
      step(4'b0011, 4'b0011, '0, "t6b");
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_zero("t6_arst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
`endif

      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic [NCH-1:0] c;
         c = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
         step(NCH'($urandom), NCH'($urandom), c, "rnd");
      end

      do_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
